// File: rtl/yellow_flag_ctrl.sv
// Issue sequencer for the combinational yellow flag unit: instruction FIFO, IDLE/EXEC/CAPTURE
// sequencing and the architectural ZNC register. Perf counters exist only with YELLOW_CTRL_PERF_EN.
module yellow_flag_ctrl #(
  parameter int DEPTH = 2,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_ins,
  input  logic [W-1:0] in_ra,
  input  logic [W-1:0] in_rb,
  input  logic         flush,
  output logic [W-1:0] dp_ins,
  output logic [W-1:0] dp_ra,
  output logic [W-1:0] dp_rb,
  output logic [2:0]   dp_znc,
  input  logic [2:0]   dp_out,
  output logic [2:0]   znc,
  output logic         done,
  output logic         br_valid,
  output logic         br_taken,
  output logic         busy
`ifdef YELLOW_CTRL_PERF_EN
  ,
  output logic [15:0]  retired_cnt,
  output logic [15:0]  taken_cnt,
  input  logic         clr_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [PW-1:0] PONE_C  = PW'(1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          in_ready_q;
  logic [W-1:0]  dp_ins_q, dp_ra_q, dp_rb_q;
  logic [2:0]    znc_q;
  logic [W-1:0]  ins_mem [DEPTH];
  logic [W-1:0]  ra_mem  [DEPTH];
  logic [W-1:0]  rb_mem  [DEPTH];

  logic       push, pop, capt_live, flag_op, br_op;
  logic [3:0] op;

  assign op        = dp_ins_q[15:12];
  assign flag_op   = (op == 4'hA) || (op == 4'hB) || (op == 4'hC);
  assign br_op     = (op == 4'hD);
  assign push      = rst_n && in_valid && in_ready_q && !flush;
  // Reset or flush during CAPTURE kills the retirement outright.
  assign capt_live = rst_n && !flush && (state_q == S_CAPT);

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_CAPT;
      S_CAPT: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      pop      = 1'b0;
      state_d  = S_IDLE;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        count_d  = count_d + ONE_C;
        wr_ptr_d = wr_ptr_q + PONE_C;
      end
      if (pop) begin
        count_d  = count_d - ONE_C;
        rd_ptr_d = rd_ptr_q + PONE_C;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b0;
      znc_q      <= 3'b000;
      dp_ins_q   <= '0;
      dp_ra_q    <= '0;
      dp_rb_q    <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= (count_d < DEPTH_C);
      if (pop) begin
        dp_ins_q <= ins_mem[rd_ptr_q];
        dp_ra_q  <= ra_mem[rd_ptr_q];
        dp_rb_q  <= rb_mem[rd_ptr_q];
      end
      if (capt_live && flag_op) znc_q <= dp_out;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[wr_ptr_q] <= in_ins;
      ra_mem[wr_ptr_q]  <= in_ra;
      rb_mem[wr_ptr_q]  <= in_rb;
    end
  end

  assign in_ready = in_ready_q;
  assign dp_ins   = dp_ins_q;
  assign dp_ra    = dp_ra_q;
  assign dp_rb    = dp_rb_q;
  assign znc      = znc_q;
  assign dp_znc   = znc_q;
  assign done     = capt_live;
  assign br_valid = capt_live && br_op;
  assign br_taken = capt_live && br_op && ((znc_q & dp_ins_q[2:0]) != 3'b000);
  assign busy     = (count_q != '0) || (state_q != S_IDLE);

`ifdef YELLOW_CTRL_PERF_EN
  logic [15:0] retired_cnt_q, taken_cnt_q;

  // Clear dominates a coincident increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
      taken_cnt_q   <= '0;
    end else begin
      if (clr_cnt)   retired_cnt_q <= '0;
      else if (done) retired_cnt_q <= retired_cnt_q + 16'd1;
      if (clr_cnt)                    taken_cnt_q <= '0;
      else if (br_valid && br_taken)  taken_cnt_q <= taken_cnt_q + 16'd1;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign taken_cnt   = taken_cnt_q;
`endif
endmodule

// File: tb/tb_yellow_flag_ctrl.sv
// Scoreboard bench for yellow_flag_ctrl: the stimulus side predicts each retirement in program order,
// a negedge monitor pops and compares whenever done is seen.
module tb_yellow_flag_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, flush;
  logic [W-1:0] in_ins, in_ra, in_rb, dp_ins, dp_ra, dp_rb;
  logic [2:0]   dp_znc, dp_out, znc;
  logic         done, br_valid, br_taken, busy;
`ifdef YELLOW_CTRL_PERF_EN
  logic [15:0]  retired_cnt, taken_cnt;
  logic         clr_cnt = 1'b0;
`endif

  yellow_flag_ctrl #(.DEPTH(2), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .in_ra(in_ra), .in_rb(in_rb), .flush(flush),
    .dp_ins(dp_ins), .dp_ra(dp_ra), .dp_rb(dp_rb), .dp_znc(dp_znc), .dp_out(dp_out),
    .znc(znc), .done(done), .br_valid(br_valid), .br_taken(br_taken), .busy(busy)
`ifdef YELLOW_CTRL_PERF_EN
    , .retired_cnt(retired_cnt), .taken_cnt(taken_cnt), .clr_cnt(clr_cnt)
`endif
  );

  // Stand-in for the yellow unit: CMP / SET / CLR semantics, garbage for everything else.
  function automatic logic [2:0] yellow(input logic [15:0] ins, input logic [15:0] ra,
                                        input logic [15:0] rb, input logic [2:0] f);
    case (ins[15:12])
      4'hA:    return {ra == rb, $signed(ra) < $signed(rb), ra < rb};
      4'hB:    return f | ins[2:0];
      4'hC:    return f & ~ins[2:0];
      default: return ra[2:0] ^ rb[2:0] ^ ins[2:0] ^ 3'b111;
    endcase
  endfunction
  assign dp_out = yellow(dp_ins, dp_ra, dp_rb, dp_znc);

  typedef struct {
    logic [15:0] ins;
    logic [2:0]  znc;
    logic        brv;
    logic        brt;
    logic        lat;
    int          acc;
  } exp_t;

  exp_t       exp_q[$];
  int         done_cyc[$];
  int         total = 0, bad = 0, cyc = 0;
  int         n_done = 0, n_br = 0, n_tk = 0, stalls = 0, m_ret = 0, m_tk = 0;
  logic [2:0] model_znc = 3'b000, retired_znc = 3'b000, arch_znc = 3'b000, pend_znc = 3'b000;
  logic       pend = 1'b0, mon_en = 1'b0, want_lat = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void model_push(input logic [15:0] ins, input logic [15:0] ra, input logic [15:0] rb);
    exp_t e;
    e.ins = ins;
    e.brv = (ins[15:12] == 4'hD);
    e.brt = e.brv && ((model_znc & ins[2:0]) != 3'b000);
    if (ins[15:12] inside {4'hA, 4'hB, 4'hC}) model_znc = yellow(ins, ra, rb, model_znc);
    e.znc = model_znc;
    e.lat = want_lat;
    e.acc = cyc + 1;
    exp_q.push_back(e);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend) begin
        arch_znc = pend_znc;
        pend = 1'b0;
      end
      chk("znc", 32'(znc), 32'(arch_znc));
      chk("dp_znc", 32'(dp_znc), 32'(arch_znc));
      if (in_valid && !in_ready && !flush) stalls++;
      if (done) begin
        n_done++;
        done_cyc.push_back(cyc);
        if (br_valid) n_br++;
        if (br_valid && br_taken) n_tk++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no retirement (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("retire_ins", 32'(dp_ins), 32'(e.ins));
          chk("br_valid", 32'(br_valid), 32'(e.brv));
          if (e.brv) chk("br_taken", 32'(br_taken), 32'(e.brt));
          if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd2);
          retired_znc = e.znc;
          pend_znc = e.znc;
          pend = 1'b1;
          m_ret++;
          if (e.brv && e.brt) m_tk++;
        end
      end else begin
        chk("br_valid_idle", 32'(br_valid), 32'd0);
      end
    end
  end

  // One clock of stimulus: inputs set just after posedge, acceptance judged at negedge.
  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] ra,
                      input logic [15:0] rb, input logic fl, output logic acc);
    in_valid = v;
    in_ins   = ins;
    in_ra    = ra;
    in_rb    = rb;
    flush    = fl;
    @(negedge clk);
    acc = v && in_ready && !fl;
    if (acc) model_push(ins, ra, rb);
    if (fl) begin
      exp_q.delete();
      model_znc = retired_znc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] ins, input logic [15:0] ra, input logic [15:0] rb);
    logic acc;
    int   n;
    n = 0;
    do begin
      step(1'b1, ins, ra, rb, 1'b0, acc);
      n++;
    end while (!acc && n < 40);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 for 40 cycles want accept of %h", ins);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || pend) && n < 200) begin
      idle(1);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    logic        acc;
    logic [2:0]  pre;
    int          d0, b0, t0;
    logic [3:0]  ops [6];
    logic [15:0] ins;
    ops[0] = 4'hA; ops[1] = 4'hB; ops[2] = 4'hC; ops[3] = 4'hD; ops[4] = 4'h0; ops[5] = 4'h5;

    rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0;
    in_ins = 16'hB007; in_ra = 16'h0; in_rb = 16'h0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_znc", 32'(znc), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_dp_ins", 32'(dp_ins), 32'd0);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    mon_en = 1'b1;

    // Single SET with latency tracking.
    want_lat = 1'b1;
    send(16'hB005, 16'h0, 16'h0);
    want_lat = 1'b0;
    drain();
    chk("set_znc", 32'(znc), 32'b101);
    chk("set_dones", 32'(n_done), 32'd1);

    // CLR down to Z only, then one taken and one not-taken branch.
    send(16'hC001, 16'h0, 16'h0);
    drain();
    b0 = n_br; t0 = n_tk;
    send(16'hD004, 16'h0, 16'h0);
    send(16'hD003, 16'h0, 16'h0);
    drain();
    chk("br_pulses", 32'(n_br - b0), 32'd2);
    chk("br_taken_pulses", 32'(n_tk - t0), 32'd1);
    chk("br_znc", 32'(znc), 32'b100);

    // Flush while a CMP is in EXEC with one entry behind it.
    pre = model_znc;
    send(16'hA000, 16'h0001, 16'h0002);
    step(1'b1, 16'hB007, 16'h0, 16'h0, 1'b0, acc);
    chk("flush_second_accept", 32'(acc), 32'd1);
    d0 = n_done;
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, acc);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_znc", 32'(znc), 32'(pre));
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    idle(4);
    chk("flush_no_done", 32'(n_done - d0), 32'd0);

    // Back-pressure burst from idle.
    drain();
    stalls = 0;
    done_cyc.delete();
    send(16'hA000, 16'h8000, 16'h0001);
    send(16'hC002, 16'h0, 16'h0);
    send(16'h0000, 16'h0, 16'h0);
    send(16'hB003, 16'h0, 16'h0);
    send(16'hD007, 16'h0, 16'h0);
    drain();
    chk("bp_stalls", 32'(stalls), 32'd2);
    chk("bp_dones", 32'(done_cyc.size()), 32'd5);
    for (int i = 1; i < done_cyc.size(); i++) chk("bp_done_gap", 32'(done_cyc[i] - done_cyc[i-1]), 32'd2);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      ins = {ops[$urandom_range(0, 5)], 9'($urandom), 3'($urandom)};
      step(($urandom % 10) < 6, ins, 16'($urandom_range(0, 3)) ^ (($urandom % 2) ? 16'h8000 : 16'h0),
           16'($urandom_range(0, 3)), ($urandom % 25) == 0, acc);
    end
    drain();
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_in_ready", 32'(in_ready), 32'd1);

`ifdef YELLOW_CTRL_PERF_EN
    chk("perf_retired", 32'(retired_cnt), 32'(m_ret[15:0]));
    chk("perf_taken", 32'(taken_cnt), 32'(m_tk[15:0]));
    clr_cnt = 1'b1;
    send(16'h0000, 16'h0, 16'h0);
    drain();
    clr_cnt = 1'b0;
    idle(1);
    chk("perf_clr_retired", 32'(retired_cnt), 32'd0);
    chk("perf_clr_taken", 32'(taken_cnt), 32'd0);
    send(16'hB004, 16'h0, 16'h0);
    send(16'hD004, 16'h0, 16'h0);
    drain();
    chk("perf_after_clr_retired", 32'(retired_cnt), 32'd2);
    chk("perf_after_clr_taken", 32'(taken_cnt), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
